// File: rtl/seg7_pkg.sv
// Shared types, glyph table and decoder for the 7-segment capture block.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        logic   valid;
        digit_t digit;
    } seg7_dec_t;

    localparam int NUM_SLOTS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment bit 0 is 'a'; entry k is the glyph for hex value k.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
        seg7_dec_t r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_PATTERN[i]) begin
                r.valid = 1'b1;
                r.digit = digit_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/segment7_capture_if.sv
// Bus bundle between a 7-segment driver/monitor and segment7_capture.
// SEG7_CAPTURE_RAW_EN adds the raw_segments observation vector.
interface segment7_capture_if;

    logic [3:0]  seg_sel;
    logic [7:0]  segments;
    logic [15:0] digit;
    logic [3:0]  digit_enable;
    logic [3:0]  digit_valid;
    logic [3:0]  decimal_point;
    logic        update;
    logic        sel_error;
`ifdef SEG7_CAPTURE_RAW_EN
    logic [31:0] raw_segments;

    modport master (
        output seg_sel, segments,
        input  digit, digit_enable, digit_valid, decimal_point, update, sel_error, raw_segments
    );
    modport slave (
        input  seg_sel, segments,
        output digit, digit_enable, digit_valid, decimal_point, update, sel_error, raw_segments
    );
`else
    modport master (
        output seg_sel, segments,
        input  digit, digit_enable, digit_valid, decimal_point, update, sel_error
    );
    modport slave (
        input  seg_sel, segments,
        output digit, digit_enable, digit_valid, decimal_point, update, sel_error
    );
`endif

endinterface

// File: rtl/seg7_slot_filter.sv
// Per-slot sample filter: repeated-sample match counter, commit strobe and
// no-strobe timeout that empties the filter.
module seg7_slot_filter #(
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       smp_vld_p0,
    input  logic [7:0] smp_pat_p0,
    output logic       commit_vld_p1,
    output logic [7:0] commit_pat_p1,
    output logic       expire_vld_p1
);

    localparam int CNT_W = $clog2(STABLE + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam bit COMMIT_EVERY = (STABLE == 1);

    logic [7:0]       prev_pat;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             pat_same;
    logic             commit_hit;
    logic             tmo_hit;

    function automatic logic [CNT_W-1:0] sat_match(input logic [CNT_W-1:0] v);
        return (v == STABLE_C) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TMO_W-1:0] sat_tmo(input logic [TMO_W-1:0] v);
        return (v == TMO_MAX) ? v : v + TMO_W'(1);
    endfunction

    always_comb begin
        pat_same   = (match_cnt != '0) && (smp_pat_p0 == prev_pat);
        match_nxt  = pat_same ? sat_match(match_cnt) : CNT_W'(1);
        commit_hit = smp_vld_p0 && (match_nxt == STABLE_C) &&
                     ((match_cnt != STABLE_C) || COMMIT_EVERY);
        tmo_hit    = !smp_vld_p0 && (tmo_cnt == TMO_LAST);
    end

    // Stage p1: filter state and commit/expire strobes
    always_ff @(posedge clk_in) begin
        if (reset) begin
            match_cnt     <= '0;
            tmo_cnt       <= '0;
            commit_vld_p1 <= 1'b0;
            expire_vld_p1 <= 1'b0;
        end else begin
            commit_vld_p1 <= commit_hit;
            expire_vld_p1 <= tmo_hit;
            if (smp_vld_p0) begin
                match_cnt <= match_nxt;
                tmo_cnt   <= '0;
            end else begin
                tmo_cnt <= sat_tmo(tmo_cnt);
                if (tmo_hit) begin
                    match_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (smp_vld_p0) begin
            prev_pat      <= smp_pat_p0;
            commit_pat_p1 <= smp_pat_p0;
        end
    end

endmodule

// File: rtl/segment7_capture.sv
// Receive side of the multiplexed 7-segment bus: rebuilds digits, enables and dps.
// SEG7_CAPTURE_RAW_EN adds raw_segments (committed normalised pattern per slot).
module segment7_capture
    import seg7_pkg::*;
#(
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int SETTLE         = 2,
    parameter int STABLE         = 2,
    parameter int TIMEOUT        = 4096
) (
    input  logic           clk_in,
    input  logic           reset,
    segment7_capture_if.slave bus
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_C = SET_W'(SETTLE);

    logic [3:0]       sel_p0;
    logic [7:0]       seg_p0;
    logic [3:0]       sel_held;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_nxt;
    logic             sel_none;
    logic             sel_multi;
    logic             sel_one;
    logic             sel_same;
    logic             smp_vld_p0;
    logic [3:0]       smp_slot_p0;
    logic             sel_error_q;

    logic [3:0]       commit_vld_p1;
    logic [3:0]       expire_vld_p1;
    logic [7:0]       commit_pat_p1 [NUM_SLOTS];

    logic [15:0]      digit_q, digit_n;
    logic [3:0]       dp_q, dp_n;
    logic [3:0]       en_q, en_n;
    logic [3:0]       val_q, val_n;
    logic             update_q, chg;
    seg7_dec_t        dec;
`ifdef SEG7_CAPTURE_RAW_EN
    logic [31:0]      raw_q, raw_n;
`endif

    function automatic logic [SET_W-1:0] sat_settle(input logic [SET_W-1:0] v);
        return (v == SETTLE_C) ? v : v + SET_W'(1);
    endfunction

    // Stage p0: registered, polarity-normalised bus
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sel_p0 <= '0;
        end else begin
            sel_p0 <= SEL_ACTIVE_LOW ? ~bus.seg_sel : bus.seg_sel;
        end
    end

    always_ff @(posedge clk_in) begin
        seg_p0 <= SEG_ACTIVE_LOW ? ~bus.segments : bus.segments;
    end

    // One sample per held select: fires only on the cycle the count first lands on SETTLE.
    always_comb begin
        sel_none    = (sel_p0 == 4'd0);
        sel_multi   = ((sel_p0 & (sel_p0 - 4'd1)) != 4'd0);
        sel_one     = !sel_none && !sel_multi;
        sel_same    = (sel_p0 == sel_held) && (settle_cnt != '0);
        settle_nxt  = '0;
        if (sel_one) begin
            settle_nxt = sel_same ? sat_settle(settle_cnt) : SET_W'(1);
        end
        smp_vld_p0  = sel_one && (settle_nxt == SETTLE_C) &&
                      !(sel_same && (settle_cnt == SETTLE_C));
        smp_slot_p0 = smp_vld_p0 ? sel_p0 : 4'd0;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            settle_cnt  <= '0;
            sel_held    <= '0;
            sel_error_q <= 1'b0;
        end else begin
            settle_cnt <= settle_nxt;
            if (sel_one) begin
                sel_held <= sel_p0;
            end
            if (sel_multi) begin
                sel_error_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        seg7_slot_filter #(
            .STABLE  (STABLE),
            .TIMEOUT (TIMEOUT)
        ) u_filter (
            .clk_in        (clk_in),
            .reset         (reset),
            .smp_vld_p0    (smp_slot_p0[i]),
            .smp_pat_p0    (seg_p0),
            .commit_vld_p1 (commit_vld_p1[i]),
            .commit_pat_p1 (commit_pat_p1[i]),
            .expire_vld_p1 (expire_vld_p1[i])
        );
    end

    // Stage p2: committed display state; update compares against the previous state
    always_comb begin
        digit_n = digit_q;
        dp_n    = dp_q;
        en_n    = en_q;
        val_n   = val_q;
        dec     = '0;
`ifdef SEG7_CAPTURE_RAW_EN
        raw_n   = raw_q;
`endif
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dec = seg7_decode(commit_pat_p1[i][6:0]);
            if (commit_vld_p1[i]) begin
                digit_n[4*i +: 4] = dec.digit;
                dp_n[i]           = commit_pat_p1[i][7];
                val_n[i]          = dec.valid;
                en_n[i]           = (commit_pat_p1[i][6:0] != SEG_BLANK);
`ifdef SEG7_CAPTURE_RAW_EN
                raw_n[8*i +: 8]   = commit_pat_p1[i];
`endif
            end else if (expire_vld_p1[i]) begin
                en_n[i]           = 1'b0;
                val_n[i]          = 1'b0;
`ifdef SEG7_CAPTURE_RAW_EN
                raw_n[8*i +: 8]   = 8'd0;
`endif
            end
        end
        chg = (digit_n != digit_q) || (dp_n != dp_q) || (en_n != en_q) || (val_n != val_q);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            digit_q  <= '0;
            dp_q     <= '0;
            en_q     <= '0;
            val_q    <= '0;
            update_q <= 1'b0;
`ifdef SEG7_CAPTURE_RAW_EN
            raw_q    <= '0;
`endif
        end else begin
            digit_q  <= digit_n;
            dp_q     <= dp_n;
            en_q     <= en_n;
            val_q    <= val_n;
            update_q <= chg;
`ifdef SEG7_CAPTURE_RAW_EN
            raw_q    <= raw_n;
`endif
        end
    end

    assign bus.digit         = digit_q;
    assign bus.decimal_point = dp_q;
    assign bus.digit_enable  = en_q;
    assign bus.digit_valid   = val_q;
    assign bus.update        = update_q;
    assign bus.sel_error     = sel_error_q;
`ifdef SEG7_CAPTURE_RAW_EN
    assign bus.raw_segments  = raw_q;
`endif

endmodule

// File: tb/tb_segment7_capture.sv
// Bench for segment7_capture: event-level display model checked every cycle,
// plus directed scan scenarios with literal expectations.
module tb_segment7_capture;

    localparam bit SEL_AL  = 1'b1;
    localparam bit SEG_AL  = 1'b1;
    localparam int SETTLE  = 2;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 4096;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    segment7_capture_if bus_if ();

    segment7_capture #(
        .SEL_ACTIVE_LOW (SEL_AL),
        .SEG_ACTIVE_LOW (SEG_AL),
        .SETTLE         (SETTLE),
        .STABLE         (STABLE),
        .TIMEOUT        (TIMEOUT)
    ) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;
    int upd_seen    = 0;
    int cycle       = 0;
    bit chk_on      = 1'b0;

    // model state
    logic [3:0]  m_sel;
    logic [7:0]  m_seg;
    int          run_slot;
    int          run_len;
    logic [7:0]  f_prev [4];
    int          f_cnt  [4];
    int          f_tmo  [4];
    bit          p_commit [4];
    bit          p_expire [4];
    logic [7:0]  p_pat    [4];
    logic [15:0] e_digit;
    logic [3:0]  e_en, e_val, e_dp;
    logic        e_upd, e_err;
    logic [31:0] e_raw;

    function automatic logic [4:0] hex_lookup(input logic [6:0] p);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 0; k < 16; k++) begin
            if (HEX[k] == p) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction

    task automatic model_reset();
        m_sel = '0; m_seg = '0; run_slot = -1; run_len = 0;
        for (int i = 0; i < 4; i++) begin
            f_prev[i] = '0; f_cnt[i] = 0; f_tmo[i] = 0;
            p_commit[i] = 1'b0; p_expire[i] = 1'b0; p_pat[i] = '0;
        end
        e_digit = '0; e_en = '0; e_val = '0; e_dp = '0; e_upd = 1'b0; e_err = 1'b0; e_raw = '0;
    endtask

    // One clock edge of the display as the rules describe it.
    task automatic model_step(input logic r, input logic [3:0] sel_raw, input logic [7:0] seg_raw);
        int ones;
        int s;
        int old;
        logic [4:0] d;
        logic [15:0] o_digit;
        logic [3:0] o_en, o_val, o_dp;
        if (r) begin
            model_reset();
            return;
        end
        o_digit = e_digit; o_en = e_en; o_val = e_val; o_dp = e_dp;
        for (int i = 0; i < 4; i++) begin
            if (p_commit[i]) begin
                d = hex_lookup(p_pat[i][6:0]);
                e_digit[4*i +: 4] = d[3:0];
                e_val[i] = d[4];
                e_dp[i]  = p_pat[i][7];
                e_en[i]  = (p_pat[i][6:0] != 7'd0);
                e_raw[8*i +: 8] = p_pat[i];
            end else if (p_expire[i]) begin
                e_en[i] = 1'b0; e_val[i] = 1'b0; e_raw[8*i +: 8] = 8'd0;
            end
            p_commit[i] = 1'b0; p_expire[i] = 1'b0;
        end
        e_upd = (o_digit != e_digit) || (o_en != e_en) || (o_val != e_val) || (o_dp != e_dp);

        ones = $countones(m_sel);
        s = -1;
        if (ones == 0) begin
            run_len = 0;
        end else if (ones > 1) begin
            e_err = 1'b1;
            run_len = 0;
        end else begin
            for (int k = 0; k < 4; k++) if (m_sel[k]) s = k;
            if (s == run_slot && run_len > 0) run_len++;
            else begin run_slot = s; run_len = 1; end
        end
        for (int i = 0; i < 4; i++) begin
            if (ones == 1 && i == s && run_len == SETTLE) begin
                f_tmo[i] = 0;
                old = f_cnt[i];
                if (f_cnt[i] > 0 && m_seg == f_prev[i]) begin
                    f_cnt[i] = (f_cnt[i] + 1 > STABLE) ? STABLE : f_cnt[i] + 1;
                    p_commit[i] = (f_cnt[i] == STABLE) && (old < STABLE || STABLE == 1);
                end else begin
                    f_prev[i] = m_seg;
                    f_cnt[i] = 1;
                    p_commit[i] = (STABLE == 1);
                end
                p_pat[i] = m_seg;
            end else if (f_tmo[i] < TIMEOUT) begin
                f_tmo[i]++;
                if (f_tmo[i] == TIMEOUT) begin
                    p_expire[i] = 1'b1;
                    f_cnt[i] = 0;
                end
            end
        end
        m_sel = SEL_AL ? ~sel_raw : sel_raw;
        m_seg = SEG_AL ? ~seg_raw : seg_raw;
    endtask

    task automatic tick(input logic [3:0] sel_on, input logic [7:0] seg_on);
        bus_if.seg_sel  = SEL_AL ? ~sel_on : sel_on;
        bus_if.segments = SEG_AL ? ~seg_on : seg_on;
        @(posedge clk);
        model_step(reset, bus_if.seg_sel, bus_if.segments);
        cycle++;
        @(negedge clk);
    endtask

    task automatic scan(input logic [3:0] mask, input logic [7:0] p3, input logic [7:0] p2,
                        input logic [7:0] p1, input logic [7:0] p0);
        logic [7:0] pats [4];
        pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
        for (int s = 3; s >= 0; s--) begin
            repeat (8) tick(mask[s] ? 4'(1 << s) : 4'd0, mask[s] ? pats[s] : 8'd0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            logic bad;
            vectors++;
            if (bus_if.update === 1'b1) upd_seen++;
            bad = (bus_if.digit !== e_digit) || (bus_if.digit_enable !== e_en) ||
                  (bus_if.digit_valid !== e_val) || (bus_if.decimal_point !== e_dp) ||
                  (bus_if.update !== e_upd) || (bus_if.sel_error !== e_err);
`ifdef SEG7_CAPTURE_RAW_EN
            if (bus_if.raw_segments !== e_raw) bad = 1'b1;
`endif
            if (bad) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got digit=%h en=%b val=%b dp=%b upd=%b err=%b, want digit=%h en=%b val=%b dp=%b upd=%b err=%b",
                         cycle, bus_if.digit, bus_if.digit_enable, bus_if.digit_valid,
                         bus_if.decimal_point, bus_if.update, bus_if.sel_error,
                         e_digit, e_en, e_val, e_dp, e_upd, e_err);
            end
        end
    end

    initial begin
        int u0;
        model_reset();
        bus_if.seg_sel  = 4'hF;
        bus_if.segments = 8'hFF;
        reset = 1'b1;
        repeat (3) tick(4'd0, 8'd0);
        reset = 1'b0;
        chk_on = 1'b1;
        check("rst_digit", 32'(bus_if.digit), 32'h0);
        check("rst_enable", 32'(bus_if.digit_enable), 32'h0);
        check("rst_sel_error", 32'(bus_if.sel_error), 32'h0);

        // idle: no select active for longer than the timeout
        repeat (5000) tick(4'd0, 8'd0);
        check("idle_update_count", 32'(upd_seen), 32'd0);
        check("idle_enable", 32'(bus_if.digit_enable), 32'h0);

        // "12:34" scan
        u0 = upd_seen;
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h66);
        check("scan1_updates", 32'(upd_seen - u0), 32'd0);
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h66);
        repeat (4) tick(4'd0, 8'd0);
        check("scan2_digit", 32'(bus_if.digit), 32'h1234);
        check("scan2_dp", 32'(bus_if.decimal_point), 32'h2);
        check("scan2_enable", 32'(bus_if.digit_enable), 32'hF);
        check("scan2_valid", 32'(bus_if.digit_valid), 32'hF);
        check("scan2_updates_one_per_slot", 32'(upd_seen - u0), 32'd4);

        // glitch on slot 0 for one scan only
        u0 = upd_seen;
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h6D);
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h66);
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h66);
        check("glitch_digit", 32'(bus_if.digit), 32'h1234);
        check("glitch_updates", 32'(upd_seen - u0), 32'd0);
        u0 = upd_seen;
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h6D);
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h6D);
        check("persist_digit", 32'(bus_if.digit), 32'h1235);
        check("persist_updates", 32'(upd_seen - u0), 32'd1);

        // blank on slot 3, unknown glyph on slot 2
        scan(4'hF, 8'h00, 8'h49, 8'hCF, 8'h6D);
        scan(4'hF, 8'h00, 8'h49, 8'hCF, 8'h6D);
        check("blank_digit", 32'(bus_if.digit), 32'h0035);
        check("blank_enable", 32'(bus_if.digit_enable), 32'h7);
        check("blank_valid", 32'(bus_if.digit_valid), 32'h3);
`ifdef SEG7_CAPTURE_RAW_EN
        check("blank_raw", bus_if.raw_segments, 32'h0049CF6D);
`endif

        // two selects active for one cycle
        repeat (3) tick(4'd0, 8'd0);
        tick(4'b0011, 8'h3F);
        repeat (3) tick(4'd0, 8'd0);
        check("sel_error_set", 32'(bus_if.sel_error), 32'h1);
        check("sel_error_no_sample", 32'(bus_if.digit), 32'h0035);
        repeat (20) tick(4'd0, 8'd0);
        check("sel_error_sticky", 32'(bus_if.sel_error), 32'h1);

        // slot 3 stops being strobed
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h66);
        scan(4'hF, 8'h06, 8'h5B, 8'hCF, 8'h66);
        check("relit_enable", 32'(bus_if.digit_enable), 32'hF);
        u0 = upd_seen;
        repeat (132) scan(4'b0111, 8'h00, 8'h5B, 8'hCF, 8'h66);
        check("timeout_enable", 32'(bus_if.digit_enable), 32'h7);
        check("timeout_valid", 32'(bus_if.digit_valid), 32'h7);
        check("timeout_digit_hold", 32'(bus_if.digit), 32'h1234);
        check("timeout_updates", 32'(upd_seen - u0), 32'd1);
`ifdef SEG7_CAPTURE_RAW_EN
        check("timeout_raw", bus_if.raw_segments, 32'h005BCF66);
`endif

        reset = 1'b1;
        repeat (2) tick(4'd0, 8'd0);
        reset = 1'b0;
        check("reset_clears_sel_error", 32'(bus_if.sel_error), 32'h0);
        check("reset_clears_digit", 32'(bus_if.digit), 32'h0);

        // reset lands in the middle of a settle
        u0 = upd_seen;
        repeat (8) tick(4'b0001, 8'h07);
        repeat (2) tick(4'd0, 8'd0);
        tick(4'b0001, 8'h07);
        reset = 1'b1;
        tick(4'b0001, 8'h07);
        reset = 1'b0;
        tick(4'b0001, 8'h07);
        repeat (10) tick(4'd0, 8'd0);
        check("midreset_digit", 32'(bus_if.digit), 32'h0);
        check("midreset_enable", 32'(bus_if.digit_enable), 32'h0);
        check("midreset_updates", 32'(upd_seen - u0), 32'd0);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
